// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared definitions for the three-phase SRAM access controller.
//   - state_t    : controller FSM states
//   - DEF_*      : default address/data widths
//   - READ_LAT / WRITE_LAT : request-to-Ack latency in cycles (sampling edge = 0)
//   - PORT_I / PORT_D      : requester indices used by the arbiter and the top
package sram_ctrl_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    localparam int READ_LAT  = 6;
    localparam int WRITE_LAT = 7;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        A_HI,
        A_LO,
        M_HI,
        M_LO,
        R_OUT,
        W_HI,
        W_LO,
        DONE
    } state_t;

endpackage

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: two-requester round-robin arbiter.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   req[1:0]  : request vector, indexed by PORT_I / PORT_D
//   accept    : the consumer takes the current grant this cycle
//   valid     : at least one request is present
//   grant     : index of the winning port (valid only when valid = 1)
// The pointer remembers the last accepted port; on a tie the other port wins.
module sram_rr_arbiter
    import sram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       valid,
    output logic       grant
);

    logic last;

    always_comb begin
        valid = |req;
        grant = PORT_I;
        if (req[PORT_I] && req[PORT_D])
            grant = ~last;
        else if (req[PORT_D])
            grant = PORT_D;
    end

    // Reset to "data was last" so the instruction port wins the first tie.
    always_ff @(posedge clk) begin
        if (rst)
            last <= PORT_D;
        else if (accept && valid)
            last <= grant;
    end

endmodule

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: sequencer and two-port arbiter for a 1024 x 32 three-phase SRAM.
// Ports:
//   Clock, Reset            : system clock, synchronous active-high reset
//   IReq/IAdx/IAck/IData    : instruction port (read only)
//   DReq/DWr/DAdx/DWData    : data port request (read or write)
//   DAck/DRData             : data port completion / read result
//   Busy                    : controller not idle
//   SramData                : shared tristate data bus
//   SramAdx                 : SRAM address, {1'b0, latched address}
//   SramOE (low), SramRNW   : SRAM bus direction controls
//   SramClk1/2/3            : MAR load / MDR load / memory write strobes
// Every output is a register; nothing combinational reaches the pins.
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAdx,
    output logic              IAck,
    output logic [DATA_W-1:0] IData,
    input  logic              DReq,
    input  logic              DWr,
    input  logic [ADDR_W-1:0] DAdx,
    input  logic [DATA_W-1:0] DWData,
    output logic              DAck,
    output logic [DATA_W-1:0] DRData,
    output logic              Busy,
    inout  wire  [DATA_W-1:0] SramData,
    output logic [ADDR_W:0]   SramAdx,
    output logic              SramOE,
    output logic              SramRNW,
    output logic              SramClk1,
    output logic              SramClk2,
    output logic              SramClk3
);

    state_t            state;
    logic              port;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic              drive;
    logic              gnt_valid;
    logic              gnt;

    sram_rr_arbiter u_arb (
        .clk    (Clock),
        .rst    (Reset),
        .req    ({DReq, IReq}),
        .accept (state == IDLE),
        .valid  (gnt_valid),
        .grant  (gnt)
    );

    // drive is only raised in the write M phase, where SramOE stays 1.
    assign SramData = drive ? wdata : {DATA_W{1'bz}};

    // Outputs are assigned on the edge that enters each state, so they line
    // up with the state they belong to.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            port     <= PORT_I;
            wr       <= 1'b0;
            wdata    <= '0;
            drive    <= 1'b0;
            SramAdx  <= '0;
            SramOE   <= 1'b1;
            SramRNW  <= 1'b1;
            SramClk1 <= 1'b0;
            SramClk2 <= 1'b0;
            SramClk3 <= 1'b0;
            IAck     <= 1'b0;
            DAck     <= 1'b0;
            IData    <= '0;
            DRData   <= '0;
            Busy     <= 1'b0;
        end else begin
            IAck <= 1'b0;
            DAck <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        port     <= gnt;
                        wr       <= (gnt == PORT_D) && DWr;
                        wdata    <= DWData;
                        SramAdx  <= {1'b0, (gnt == PORT_I) ? IAdx : DAdx};
                        SramClk1 <= 1'b1;
                        Busy     <= 1'b1;
                        state    <= A_HI;
                    end
                end
                A_HI: begin
                    SramClk1 <= 1'b0;
                    state    <= A_LO;
                end
                A_LO: begin
                    SramClk2 <= 1'b1;
                    SramRNW  <= ~wr;
                    drive    <= wr;
                    state    <= M_HI;
                end
                M_HI: begin
                    SramClk2 <= 1'b0;
                    state    <= M_LO;
                end
                M_LO: begin
                    // Release the bus before the SRAM may be asked to drive it.
                    drive <= 1'b0;
                    if (wr) begin
                        SramClk3 <= 1'b1;
                        state    <= W_HI;
                    end else begin
                        SramOE <= 1'b0;
                        state  <= R_OUT;
                    end
                end
                R_OUT: begin
                    SramOE <= 1'b1;
                    if (port == PORT_I)
                        IData <= SramData;
                    else
                        DRData <= SramData;
                    state <= DONE;
                end
                W_HI: begin
                    SramClk3 <= 1'b0;
                    state    <= W_LO;
                end
                W_LO: begin
                    SramRNW <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    IAck  <= (port == PORT_I);
                    DAck  <= (port == PORT_D);
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: directed bench for sram_access_ctrl with a behavioural
// three-phase SRAM (MAR on Clock1 fall, MDR on Clock2 fall, write on Clock3 fall).
module tb_sram_access_ctrl;
    import sram_ctrl_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        IReq;
    logic [9:0]  IAdx;
    logic        IAck;
    logic [31:0] IData;
    logic        DReq;
    logic        DWr;
    logic [9:0]  DAdx;
    logic [31:0] DWData;
    logic        DAck;
    logic [31:0] DRData;
    logic        Busy;
    wire  [31:0] SramData;
    logic [10:0] SramAdx;
    logic        SramOE;
    logic        SramRNW;
    logic        SramClk1;
    logic        SramClk2;
    logic        SramClk3;

    always #5 Clock = ~Clock;

    sram_access_ctrl #(.ADDR_W(10), .DATA_W(32)) dut (
        .Clock(Clock), .Reset(Reset),
        .IReq(IReq), .IAdx(IAdx), .IAck(IAck), .IData(IData),
        .DReq(DReq), .DWr(DWr), .DAdx(DAdx), .DWData(DWData),
        .DAck(DAck), .DRData(DRData), .Busy(Busy),
        .SramData(SramData), .SramAdx(SramAdx), .SramOE(SramOE), .SramRNW(SramRNW),
        .SramClk1(SramClk1), .SramClk2(SramClk2), .SramClk3(SramClk3)
    );

    // SRAM model
    logic [31:0] mem [0:1023];
    logic [9:0]  mar;
    logic [31:0] mdr;
    always @(negedge SramClk1) mar <= SramAdx[9:0];
    always @(negedge SramClk2) mdr <= SramRNW ? mem[mar] : SramData;
    always @(negedge SramClk3) mem[mar] <= mdr;
    assign SramData = SramOE ? 32'bz : mdr;

    int checks = 0;
    int fails  = 0;
    int clk3_cnt = 0;
    always @(posedge SramClk3) clk3_cnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Bus and strobe safety, checked every cycle outside reset.
    always @(negedge Clock) begin
        if (Reset === 1'b0) begin
            checks++;
            if (!SramOE && !SramRNW) begin
                fails++;
                $display("FAIL bus_conflict: OE=%b RNW=%b expected no OE=0 during write", SramOE, SramRNW);
            end
            checks++;
            if (32'(SramClk1) + 32'(SramClk2) + 32'(SramClk3) > 32'd1) begin
                fails++;
                $display("FAIL strobe_overlap: clk123=%b%b%b expected at most one high",
                         SramClk1, SramClk2, SramClk3);
            end
        end
    end

    task automatic chk_reset_vals(input string nm);
        chk({nm, " busy"}, 32'(Busy), 32'd0);
        chk({nm, " oe"}, 32'(SramOE), 32'd1);
        chk({nm, " rnw"}, 32'(SramRNW), 32'd1);
        chk({nm, " clks"}, 32'({SramClk1, SramClk2, SramClk3}), 32'd0);
        chk({nm, " adx"}, 32'(SramAdx), 32'd0);
        chk({nm, " acks"}, 32'({IAck, DAck}), 32'd0);
    endtask

    // One transaction from request to Ack; request dropped on seeing Ack.
    task automatic run_txn(input string nm, input logic is_d, input logic wr, input logic [9:0] adx,
                           input logic [31:0] wdata, input logic [31:0] exp, input int exp_lat);
        int lat;
        int c3;
        logic other_ack;
        logic [31:0] other_q;
        lat = -1;
        other_ack = 1'b0;
        c3 = clk3_cnt;
        other_q = is_d ? IData : DRData;
        if (is_d) begin
            DReq = 1'b1; DWr = wr; DAdx = adx; DWData = wdata;
        end else begin
            IReq = 1'b1; IAdx = adx;
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge Clock); #1;
            if (c == 0) chk({nm, " busy"}, 32'(Busy), 32'd1);
            if (is_d ? IAck : DAck) other_ack = 1'b1;
            if (is_d ? DAck : IAck) begin
                lat = c;
                break;
            end
        end
        IReq = 1'b0; DReq = 1'b0; DWr = 1'b0;
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        if (!wr) chk({nm, " rdata"}, is_d ? DRData : IData, exp);
        chk({nm, " other_ack"}, 32'(other_ack), 32'd0);
        chk({nm, " other_rdata"}, is_d ? IData : DRData, other_q);
        chk({nm, " clk3_pulses"}, 32'(clk3_cnt - c3), wr ? 32'd1 : 32'd0);
    endtask

    typedef struct {
        string       nm;
        logic        is_d;
        logic        wr;
        logic [9:0]  adx;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c3;
        int lat;
        int ack_cnt;
        logic [31:0] exp_q;

        tbl[0] = '{"wr003", 1'b1, 1'b1, 10'h003, 32'h12345678, 32'h0,        WRITE_LAT};
        tbl[1] = '{"rd003", 1'b1, 1'b0, 10'h003, 32'h0,        32'h12345678, READ_LAT};
        tbl[2] = '{"wr005", 1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 32'h0,        WRITE_LAT};
        tbl[3] = '{"ird005", 1'b0, 1'b0, 10'h005, 32'h0,       32'hDEADBEEF, READ_LAT};
        tbl[4] = '{"wr00a", 1'b1, 1'b1, 10'h00A, 32'h11111111, 32'h0,        WRITE_LAT};
        tbl[5] = '{"ird00a", 1'b0, 1'b0, 10'h00A, 32'h0,       32'h11111111, READ_LAT};
        tbl[6] = '{"wr3ff", 1'b1, 1'b1, 10'h3FF, 32'hA5A5A5A5, 32'h0,        WRITE_LAT};
        tbl[7] = '{"rd3ff", 1'b1, 1'b0, 10'h3FF, 32'h0,        32'hA5A5A5A5, READ_LAT};
        tbl[8] = '{"wr000", 1'b1, 1'b1, 10'h000, 32'h0F0F0F0F, 32'h0,        WRITE_LAT};
        tbl[9] = '{"ird000", 1'b0, 1'b0, 10'h000, 32'h0,       32'h0F0F0F0F, READ_LAT};

        // Reset held with both requests high.
        Reset = 1'b1; IReq = 1'b1; DReq = 1'b1; DWr = 1'b0;
        IAdx = 10'h005; DAdx = 10'h003; DWData = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock); #1;
            chk_reset_vals($sformatf("rst%0d", i));
            chk($sformatf("rst%0d rdata", i), IData | DRData, 32'h0);
        end
        // Release: the instruction request is taken on the very next edge.
        Reset = 1'b0; DReq = 1'b0;
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            @(posedge Clock); #1;
            if (c == 0) begin
                chk("rel busy", 32'(Busy), 32'd1);
                chk("rel clk1", 32'(SramClk1), 32'd1);
                chk("rel adx", 32'(SramAdx), 32'h005);
            end
            if (IAck) begin
                lat = c;
                break;
            end
        end
        IReq = 1'b0;
        chk("rel latency", 32'(lat), 32'(READ_LAT));

        foreach (tbl[i])
            run_txn(tbl[i].nm, tbl[i].is_d, tbl[i].wr, tbl[i].adx, tbl[i].wdata, tbl[i].exp, tbl[i].lat);

        // Reset during M_LO of a write: aborted, no Ack, memory untouched.
        c3 = clk3_cnt;
        DReq = 1'b1; DWr = 1'b1; DAdx = 10'h00A; DWData = 32'hCAFEF00D;
        repeat (4) @(posedge Clock);
        #1;
        chk("abort mlo rnw", 32'(SramRNW), 32'd0);
        Reset = 1'b1;
        @(posedge Clock); #1;
        chk_reset_vals("abort");
        Reset = 1'b0; DReq = 1'b0; DWr = 1'b0;
        ack_cnt = 0;
        repeat (8) begin
            @(posedge Clock); #1;
            if (DAck || IAck) ack_cnt++;
        end
        chk("abort no_ack", 32'(ack_cnt), 32'd0);
        chk("abort clk3", 32'(clk3_cnt - c3), 32'd0);
        run_txn("abort_rb", 1'b0, 1'b0, 10'h00A, 32'h0, 32'h11111111, READ_LAT);

        // Tie arbitration from a fresh reset: I, D, I, D, each 7 cycles apart.
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        IReq = 1'b1; IAdx = 10'h003; DReq = 1'b1; DWr = 1'b0; DAdx = 10'h005;
        ack_cnt = 0;
        for (int c = 0; c < 40 && ack_cnt < 4; c++) begin
            @(posedge Clock); #1;
            if (IAck || DAck) begin
                exp_q = (ack_cnt % 2 == 0) ? 32'h12345678 : 32'hDEADBEEF;
                chk($sformatf("tie%0d cycle", ack_cnt), 32'(c), 32'(READ_LAT + 7 * ack_cnt));
                chk($sformatf("tie%0d port", ack_cnt), 32'({IAck, DAck}),
                    (ack_cnt % 2 == 0) ? 32'b10 : 32'b01);
                chk($sformatf("tie%0d data", ack_cnt), (ack_cnt % 2 == 0) ? IData : DRData, exp_q);
                ack_cnt++;
            end
        end
        IReq = 1'b0; DReq = 1'b0;
        chk("tie ack_count", 32'(ack_cnt), 32'd4);
        repeat (2) @(posedge Clock);
        #1;
        chk("tie idle busy", 32'(Busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Sequencing controller and two-port arbiter for the 1024 x 32 three-phase SRAM.
- Generates the SRAM phase strobes (Clock1/Clock2/Clock3), OE and RNW from one system clock.
- Drives and releases the shared 32-bit tristate data bus.
- Shares the SRAM between an instruction port (read-only) and a data port (read/write) with round-robin arbitration.
- Sits between the processor fetch/memory stages and the SRAM instance.

Parameters:
ADDR_W, 10, word address width (1024 words; SramAdx[10] tied 0)
DATA_W, 32, data word width

Ports:
Clock  in  1  system clock, all state updates on posedge
Reset  in  1  synchronous, active-high reset
IReq  in  1  instruction port request; held with IAdx until IAck
IAdx  in  ADDR_W  instruction word address
IAck  out  1  one-cycle pulse: IData valid
IData  out  DATA_W  instruction read data; holds last value
DReq  in  1  data port request; held with DWr/DAdx/DWData until DAck
DWr  in  1  1 = write, 0 = read
DAdx  in  ADDR_W  data word address
DWData  in  DATA_W  write data
DAck  out  1  one-cycle pulse: write done / DRData valid
DRData  out  DATA_W  data read result; holds last value
Busy  out  1  high in every state except IDLE
SramData  inout  DATA_W  SRAM DataBus
SramAdx  out  ADDR_W+1  SRAM AdxBus, {1'b0, latched address}
SramOE  out  1  SRAM output enable, active low (SRAM drives bus when 0)
SramRNW  out  1  1 = read, 0 = write
SramClk1  out  1  SRAM Clock1 (MAR load)
SramClk2  out  1  SRAM Clock2 (MDR load)
SramClk3  out  1  SRAM Clock3 (memory write)

Behaviour:
- All SRAM-side outputs, Acks and read data are registered. No combinational path from inputs to outputs.
- Reset values:
  - state IDLE
  - SramClk1/2/3 = 0, SramOE = 1, SramRNW = 1, SramAdx = 0
  - SramData released (z)
  - IAck = DAck = 0, IData = DRData = 0, Busy = 0
  - round-robin pointer set so the instruction port wins the first tie.
- FSM states: IDLE, A_HI, A_LO, M_HI, M_LO, R_OUT, W_HI, W_LO, DONE.
- IDLE:
  - Sample IReq and DReq.
  - Only one request: grant it.
  - Both requesting: grant the port not granted last, then toggle the pointer.
  - On grant: latch address, Wr (forced 0 for the instruction port) and write data; go to A_HI.
- A_HI: SramAdx valid, SramClk1 = 1. Then A_LO (SramClk1 = 0, address held).
- M_HI: SramClk2 = 1. Then M_LO (SramClk2 = 0).
  - Read: SramRNW = 1.
  - Write: SramRNW = 0, SramOE = 1, controller drives SramData from M_HI through M_LO.
- Read path: M_LO -> R_OUT.
  - R_OUT: SramOE = 0; SramData captured into the granted port's read register at the end of R_OUT.
  - Then DONE.
- Write path: M_LO -> W_HI (SramClk3 = 1, SramRNW = 0) -> W_LO (SramClk3 = 0, SramRNW = 0) -> DONE.
  - SramRNW returns to 1 in DONE.
- DONE: Ack pulse to the granted port only; then IDLE.
- Latency, counting the IDLE sampling edge as cycle 0:
  - read Ack in cycle 6
  - write Ack in cycle 7
  - minimum one IDLE cycle between transactions
- Invariant: the controller never drives SramData while SramOE = 0. Only the granted port's read register updates.
- Requests dropped before Ack are a protocol violation; the transaction still completes with the latched values.
- Synchronous Reset in any state forces the reset values on the next edge. The transaction is aborted with no Ack.
  - Reset before W_HI: memory is unmodified.
  - Reset in W_HI or W_LO: the write has already occurred.
- No address checks: the 10-bit address is used directly, so there is no wrap-around case.

Decomposition:
- Package sram_ctrl_pkg holds:
  - the state enum
  - ADDR_W/DATA_W defaults
  - READ_LAT = 6 and WRITE_LAT = 7
  - the port index constants PORT_I/PORT_D
- Sub-module sram_rr_arbiter: 2-requester round-robin, with grant plus a pointer update on accept.
- FSM, strobe registers and the tristate driver stay in the top module.

Test Plan:
- Single read: preload word 0x003 = 0x12345678 by a prior write; pulse DReq/DWr=0/DAdx=0x003 -> DAck in cycle 6, DRData = 0x12345678, IAck stays 0.
- Write then readback: DWr=1, DAdx=0x005, DWData=0xDEADBEEF -> DAck in cycle 7, exactly one SramClk3 pulse. IReq with IAdx=0x005 -> IData = 0xDEADBEEF.
- Tie arbitration: IReq and DReq held high continuously (both reads) -> grants alternate I, D, I, D starting with I. Each Ack 7 cycles apart (6 + 1 IDLE).
- Reset during M_LO of a write of 0xCAFEF00D to 0x00A (old 0x11111111) -> outputs return to reset values on the next edge, no DAck; readback of 0x00A = 0x11111111.
- Bus safety: bench monitor over all scenarios -> SramData never driven by both sides (OE=0 while controller drives flagged as error). SramClk1/2/3 never high in the same cycle.
- Reset idle check: hold Reset 3 cycles with requests high -> no Acks, Busy=0, SramOE=1, SramRNW=1. First request after release accepted on the next edge.
